// File: rtl/instr_dispatcher_pkg.sv
// Shared types and constants for the instruction dispatcher: opcode decode, instruction layout, FSM states.
// Decode helpers map an opcode onto the execution unit that consumes it.
package instr_dispatcher_pkg;

  localparam int INSTR_WIDTH       = 80;
  localparam int NUM_UNITS         = 3;

  localparam int OP_CODE_LSB       = 0;
  localparam int CALC_LENGTH_LSB   = 8;
  localparam int ACC_ADDR_LSB      = 40;
  localparam int BUFFER_ADDR_LSB   = 56;

  typedef struct packed {
    logic [INSTR_WIDTH-BUFFER_ADDR_LSB-1:0]    buffer_addr;
    logic [BUFFER_ADDR_LSB-ACC_ADDR_LSB-1:0]   acc_addr;
    logic [ACC_ADDR_LSB-CALC_LENGTH_LSB-1:0]   calc_length;
    logic [CALC_LENGTH_LSB-OP_CODE_LSB-1:0]    op_code;
  } instr_type;

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_HALT        = 8'h01;
  localparam logic [7:0] OP_SYNC        = 8'hFF;
  localparam logic [7:0] WEIGHT_MASK    = 8'hF8;
  localparam logic [7:0] WEIGHT_MATCH   = 8'h08;
  localparam logic [7:0] MATMUL_MASK    = 8'hE0;
  localparam logic [7:0] MATMUL_MATCH   = 8'h20;
  localparam logic [7:0] ACTIVATE_MASK  = 8'h80;
  localparam logic [7:0] ACTIVATE_MATCH = 8'h80;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_SYNC,
    ST_HALTED
  } dispatch_state_type;

  typedef enum logic [1:0] {
    UNIT_NONE,
    UNIT_WEIGHT,
    UNIT_MATMUL,
    UNIT_ACTIVATE
  } unit_sel_type;

  // SYNC shares the ACTIVATE prefix, so it is excluded explicitly.
  function automatic unit_sel_type decode_unit(input logic [7:0] op);
    unit_sel_type sel;
    sel = UNIT_NONE;
    if ((op & WEIGHT_MASK) == WEIGHT_MATCH)
      sel = UNIT_WEIGHT;
    else if ((op & MATMUL_MASK) == MATMUL_MATCH)
      sel = UNIT_MATMUL;
    else if (((op & ACTIVATE_MASK) == ACTIVATE_MATCH) && (op != OP_SYNC))
      sel = UNIT_ACTIVATE;
    return sel;
  endfunction

endpackage

// File: rtl/instr_dispatcher_if.sv
// Bundle of FIFO-side and unit-side signals around the instruction dispatcher.
// master is the dispatcher's view; slave is the view of the FIFO, units and host control.
interface instr_dispatcher_if;
  import instr_dispatcher_pkg::*;

  instr_type fifo_data;
  logic      fifo_empty;
  logic      fifo_next_en;

  instr_type weight_instr;
  instr_type matmul_instr;
  instr_type activate_instr;
  logic      weight_en;
  logic      matmul_en;
  logic      activate_en;
  logic      weight_busy;
  logic      matmul_busy;
  logic      activate_busy;

  logic      synchronize;
  logic      halted;
  logic      resume;
  logic      illegal_op;

  modport master (
    input  fifo_data, fifo_empty,
    input  weight_busy, matmul_busy, activate_busy,
    input  resume,
    output fifo_next_en,
    output weight_instr, matmul_instr, activate_instr,
    output weight_en, matmul_en, activate_en,
    output synchronize, halted, illegal_op
  );

  modport slave (
    output fifo_data, fifo_empty,
    output weight_busy, matmul_busy, activate_busy,
    output resume,
    input  fifo_next_en,
    input  weight_instr, matmul_instr, activate_instr,
    input  weight_en, matmul_en, activate_en,
    input  synchronize, halted, illegal_op
  );
endinterface

// File: rtl/instr_dispatcher_unit_holdoff.sv
// Per-unit holdoff: masks a unit as busy for HOLDOFF_CYCLES after an issue,
// covering the gap before the unit raises its own busy.
module unit_holdoff #(
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic load,
  output logic free
);

  localparam int CNT_WIDTH = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  logic [CNT_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt_reg <= '0;
    else if (load)
      cnt_reg <= CNT_WIDTH'(HOLDOFF_CYCLES);
    else if (cnt_reg != '0)
      cnt_reg <= cnt_reg - CNT_WIDTH'(1);
  end

  // A busy that rises in the same cycle as the check already blocks the issue.
  assign free = !busy && (cnt_reg == '0);

endmodule

// File: rtl/instr_dispatcher.sv
// Instruction dispatcher: pops the instruction FIFO, issues to weight/matmul/activate units in order,
// executes NOP/HALT/SYNC locally. Define INSTR_DISPATCHER_PERF_EN to add perf_issued/perf_stall counters.
module instr_dispatcher
  import instr_dispatcher_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 1,
  parameter int PERF_CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  instr_dispatcher_if.master        bus
`ifdef INSTR_DISPATCHER_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_issued,
  output logic [PERF_CNT_WIDTH-1:0] perf_stall
`endif
);

  dispatch_state_type   state_reg;
  dispatch_state_type   state_next;
  instr_type            hold_reg;
  unit_sel_type         unit_sel;
  logic                 synchronize_reg;
  logic                 illegal_op_reg;

  logic                 pop;
  logic                 sync_done;
  logic                 set_illegal;
  logic [NUM_UNITS-1:0] busy_vec;
  logic [NUM_UNITS-1:0] free_vec;
  logic [NUM_UNITS-1:0] target_vec;
  logic [NUM_UNITS-1:0] issue_vec;
  logic [NUM_UNITS-1:0] en_vec;
  instr_type            instr_vec [NUM_UNITS];

  // Unit index order: 0 weight, 1 matmul, 2 activate.
  assign busy_vec = {bus.activate_busy, bus.matmul_busy, bus.weight_busy};
  assign unit_sel = decode_unit(hold_reg.op_code);

  always_comb begin
    target_vec = '0;
    case (unit_sel)
      UNIT_WEIGHT:   target_vec = 3'b001;
      UNIT_MATMUL:   target_vec = 3'b010;
      UNIT_ACTIVATE: target_vec = 3'b100;
      default:       target_vec = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      logic      en_reg;
      instr_type instr_reg;

      unit_holdoff #(
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
      ) u_holdoff (
        .clk  (clk),
        .rst  (rst),
        .busy (busy_vec[gi]),
        .load (issue_vec[gi]),
        .free (free_vec[gi])
      );

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          en_reg    <= 1'b0;
          instr_reg <= '0;
        end else begin
          en_reg <= issue_vec[gi];
          if (issue_vec[gi])
            instr_reg <= hold_reg;
        end
      end

      assign en_vec[gi]    = en_reg;
      assign instr_vec[gi] = instr_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= ST_FETCH;
      hold_reg        <= '0;
      synchronize_reg <= 1'b0;
      illegal_op_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      synchronize_reg <= sync_done;
      if (pop)
        hold_reg <= bus.fifo_data;
      if (set_illegal)
        illegal_op_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    pop         = 1'b0;
    issue_vec   = '0;
    sync_done   = 1'b0;
    set_illegal = 1'b0;
    unique case (state_reg)
      ST_FETCH: begin
        // Popping is suppressed while reset is held so no instruction is lost.
        if (rst && !bus.fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (target_vec != '0) begin
          if ((target_vec & free_vec) != '0) begin
            issue_vec  = target_vec;
            state_next = ST_FETCH;
          end
        end else if (hold_reg.op_code == OP_SYNC) begin
          state_next = ST_WAIT_SYNC;
        end else if (hold_reg.op_code == OP_HALT) begin
          state_next = ST_HALTED;
        end else begin
          set_illegal = (hold_reg.op_code != OP_NOP);
          state_next  = ST_FETCH;
        end
      end
      ST_WAIT_SYNC: begin
        if (&free_vec) begin
          sync_done  = 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALTED: begin
        if (bus.resume)
          state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  assign bus.fifo_next_en   = pop;
  assign bus.weight_en      = en_vec[0];
  assign bus.matmul_en      = en_vec[1];
  assign bus.activate_en    = en_vec[2];
  assign bus.weight_instr   = instr_vec[0];
  assign bus.matmul_instr   = instr_vec[1];
  assign bus.activate_instr = instr_vec[2];
  assign bus.synchronize    = synchronize_reg;
  assign bus.halted         = (state_reg == ST_HALTED);
  assign bus.illegal_op     = illegal_op_reg;

`ifdef INSTR_DISPATCHER_PERF_EN
  logic                      stall;
  logic [PERF_CNT_WIDTH-1:0] perf_issued_reg;
  logic [PERF_CNT_WIDTH-1:0] perf_stall_reg;

  assign stall = ((state_reg == ST_ISSUE) && (target_vec != '0) && ((target_vec & free_vec) == '0)) ||
                 ((state_reg == ST_WAIT_SYNC) && !(&free_vec));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issued_reg <= '0;
      perf_stall_reg  <= '0;
    end else begin
      if (|en_vec)
        perf_issued_reg <= perf_issued_reg + PERF_CNT_WIDTH'(1);
      if (stall)
        perf_stall_reg <= perf_stall_reg + PERF_CNT_WIDTH'(1);
    end
  end

  assign perf_issued = perf_issued_reg;
  assign perf_stall  = perf_stall_reg;
`endif

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher: a small array FIFO feeds the DUT, unit busy lines are driven per scenario.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_dispatcher;
  import instr_dispatcher_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_dispatcher_if dif ();

`ifdef INSTR_DISPATCHER_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  instr_dispatcher #(
    .HOLDOFF_CYCLES (1),
    .PERF_CNT_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.master)
`ifdef INSTR_DISPATCHER_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  // Bench-side FIFO
  logic [79:0] fmem [16];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  int unsigned w_cnt  = 0;
  int unsigned m_cnt  = 0;
  int unsigned a_cnt  = 0;
  int unsigned s_cnt  = 0;

  assign dif.fifo_empty = (rd_ptr == wr_ptr);
  assign dif.fifo_data  = fmem[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (dif.fifo_next_en) rd_ptr <= rd_ptr + 1;
    if (dif.weight_en)    w_cnt  <= w_cnt + 1;
    if (dif.matmul_en)    m_cnt  <= m_cnt + 1;
    if (dif.activate_en)  a_cnt  <= a_cnt + 1;
    if (dif.synchronize)  s_cnt  <= s_cnt + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [79:0] W1 = 80'hABCDEF_1234_00000040_08;
  localparam logic [79:0] W2 = 80'h123456_789A_BCDEF012_0F;
  localparam logic [79:0] W3 = 80'h0A0B0C_0D0E_01020304_09;
  localparam logic [79:0] W5 = 80'h5555AA_7777_0000FFFF_0C;
  localparam logic [79:0] M1 = 80'h000100_0200_00000010_20;
  localparam logic [79:0] M2 = 80'hFEDCBA_9876_00000100_3F;
  localparam logic [79:0] M3 = 80'h303030_4040_50505050_21;
  localparam logic [79:0] A1 = 80'h112233_4455_66778899_80;
  localparam logic [79:0] S1 = 80'h000000_0000_00000000_FF;
  localparam logic [79:0] N1 = 80'h000000_0000_00000000_00;
  localparam logic [79:0] H1 = 80'h000000_0000_00000000_01;
  localparam logic [79:0] IL = 80'h000000_0000_00000000_40;

  task automatic push(input logic [79:0] v);
    fmem[wr_ptr[3:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (dif.fifo_next_en !== 1'b0) $display("FAIL rst_next_en: got %b want 0", dif.fifo_next_en); else n_pass++;
    n_chk++; if ({dif.weight_en, dif.matmul_en, dif.activate_en} !== 3'b000) $display("FAIL rst_en: got %b want 000", {dif.weight_en, dif.matmul_en, dif.activate_en}); else n_pass++;
    n_chk++; if (dif.weight_instr !== 80'h0) $display("FAIL rst_weight_instr: got %h want 0", dif.weight_instr); else n_pass++;
    n_chk++; if ({dif.synchronize, dif.halted, dif.illegal_op} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {dif.synchronize, dif.halted, dif.illegal_op}); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    $display("reset: done");
  endtask

  task automatic test_weight;
    int unsigned p0;
    p0 = rd_ptr;
    push(W1);
    #1;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL wt_next_en_t0: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.weight_en !== 1'b0) $display("FAIL wt_en_t1: got %b want 0", dif.weight_en); else n_pass++;
    n_chk++; if (dif.fifo_next_en !== 1'b0) $display("FAIL wt_next_en_t1: got %b want 0", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.weight_en !== 1'b1) $display("FAIL wt_en_t2: got %b want 1", dif.weight_en); else n_pass++;
    n_chk++; if (dif.weight_instr !== W1) $display("FAIL wt_instr: got %h want %h", dif.weight_instr, W1); else n_pass++;
    n_chk++; if ({dif.matmul_en, dif.activate_en} !== 2'b00) $display("FAIL wt_other_en: got %b want 00", {dif.matmul_en, dif.activate_en}); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.weight_en !== 1'b0) $display("FAIL wt_en_t3: got %b want 0", dif.weight_en); else n_pass++;
    n_chk++; if (rd_ptr - p0 !== 1) $display("FAIL wt_pops: got %0d want 1", rd_ptr - p0); else n_pass++;
    $display("weight: instr=%h", dif.weight_instr);
  endtask

  task automatic test_matmul_stall;
    int unsigned p0;
    p0 = rd_ptr;
    dif.matmul_busy = 1'b1;
    push(M1);
    push(W2);
    #1;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL mm_next_en_t0: got %b want 1", dif.fifo_next_en); else n_pass++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) dif.matmul_busy = 1'b0;
      n_chk++; if (dif.matmul_en !== 1'b0) $display("FAIL mm_en_stall_%0d: got %b want 0", k, dif.matmul_en); else n_pass++;
      n_chk++; if (rd_ptr - p0 !== 1) $display("FAIL mm_pops_stall_%0d: got %0d want 1", k, rd_ptr - p0); else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (dif.matmul_en !== 1'b1) $display("FAIL mm_en_release: got %b want 1", dif.matmul_en); else n_pass++;
    n_chk++; if (dif.matmul_instr !== M1) $display("FAIL mm_instr: got %h want %h", dif.matmul_instr, M1); else n_pass++;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL mm_next_pop: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.matmul_en !== 1'b0) $display("FAIL mm_en_one_cycle: got %b want 0", dif.matmul_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.weight_en !== 1'b1) $display("FAIL mm_follow_wt_en: got %b want 1", dif.weight_en); else n_pass++;
    n_chk++; if (dif.weight_instr !== W2) $display("FAIL mm_follow_wt_instr: got %h want %h", dif.weight_instr, W2); else n_pass++;
    @(negedge clk);
    $display("matmul_stall: instr=%h", dif.matmul_instr);
  endtask

  task automatic test_act_sync;
    int unsigned s0;
    s0 = s_cnt;
    push(A1);
    push(S1);
    push(N1);
    #1;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL as_next_en_t0: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.activate_en !== 1'b0) $display("FAIL as_act_en_t1: got %b want 0", dif.activate_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.activate_en !== 1'b1) $display("FAIL as_act_en_t2: got %b want 1", dif.activate_en); else n_pass++;
    n_chk++; if (dif.activate_instr !== A1) $display("FAIL as_act_instr: got %h want %h", dif.activate_instr, A1); else n_pass++;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL as_sync_pop: got %b want 1", dif.fifo_next_en); else n_pass++;
    dif.activate_busy = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) dif.activate_busy = 1'b0;
      n_chk++; if (dif.synchronize !== 1'b0) $display("FAIL as_sync_early_%0d: got %b want 0", k, dif.synchronize); else n_pass++;
      n_chk++; if (dif.fifo_next_en !== 1'b0) $display("FAIL as_no_pop_%0d: got %b want 0", k, dif.fifo_next_en); else n_pass++;
    end
    @(negedge clk);
    n_chk++; if (dif.synchronize !== 1'b1) $display("FAIL as_sync_pulse: got %b want 1", dif.synchronize); else n_pass++;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL as_pop_after_sync: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.synchronize !== 1'b0) $display("FAIL as_sync_one_cycle: got %b want 0", dif.synchronize); else n_pass++;
    n_chk++; if (s_cnt - s0 !== 1) $display("FAIL as_sync_count: got %0d want 1", s_cnt - s0); else n_pass++;
    @(negedge clk);
    $display("act_sync: sync pulses=%0d", s_cnt - s0);
  endtask

  task automatic test_halt;
    int unsigned p0;
    dif.resume = 1'b1;
    @(negedge clk);
    dif.resume = 1'b0;
    n_chk++; if (dif.halted !== 1'b0) $display("FAIL ht_resume_ignored: got %b want 0", dif.halted); else n_pass++;
    p0 = rd_ptr;
    push(H1);
    push(W3);
    #1;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL ht_next_en_t0: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.halted !== 1'b0) $display("FAIL ht_halted_t1: got %b want 0", dif.halted); else n_pass++;
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      n_chk++; if (dif.halted !== 1'b1) $display("FAIL ht_halted_%0d: got %b want 1", k, dif.halted); else n_pass++;
      n_chk++; if (dif.fifo_next_en !== 1'b0) $display("FAIL ht_no_pop_%0d: got %b want 0", k, dif.fifo_next_en); else n_pass++;
    end
    n_chk++; if (rd_ptr - p0 !== 1) $display("FAIL ht_pops: got %0d want 1", rd_ptr - p0); else n_pass++;
    dif.resume = 1'b1;
    @(negedge clk);
    dif.resume = 1'b0;
    n_chk++; if (dif.halted !== 1'b0) $display("FAIL ht_resumed: got %b want 0", dif.halted); else n_pass++;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL ht_pop_after_resume: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.weight_en !== 1'b0) $display("FAIL ht_wt_en_early: got %b want 0", dif.weight_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.weight_en !== 1'b1) $display("FAIL ht_wt_en: got %b want 1", dif.weight_en); else n_pass++;
    n_chk++; if (dif.weight_instr !== W3) $display("FAIL ht_wt_instr: got %h want %h", dif.weight_instr, W3); else n_pass++;
    @(negedge clk);
    $display("halt: resumed, weight_instr=%h", dif.weight_instr);
  endtask

  task automatic test_illegal;
    int unsigned e0;
    e0 = w_cnt + m_cnt + a_cnt;
    push(IL);
    push(M2);
    #1;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL il_next_en_t0: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.illegal_op !== 1'b0) $display("FAIL il_flag_t1: got %b want 0", dif.illegal_op); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.illegal_op !== 1'b1) $display("FAIL il_flag_set: got %b want 1", dif.illegal_op); else n_pass++;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL il_next_pop: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (w_cnt + m_cnt + a_cnt - e0 !== 0) $display("FAIL il_no_en: got %0d want 0", w_cnt + m_cnt + a_cnt - e0); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.matmul_en !== 1'b1) $display("FAIL il_mm_en: got %b want 1", dif.matmul_en); else n_pass++;
    n_chk++; if (dif.matmul_instr !== M2) $display("FAIL il_mm_instr: got %h want %h", dif.matmul_instr, M2); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.illegal_op !== 1'b1) $display("FAIL il_flag_sticky: got %b want 1", dif.illegal_op); else n_pass++;
    $display("illegal: flag=%b", dif.illegal_op);
  endtask

  task automatic test_reset_mid;
    int unsigned p0;
    int unsigned m0;
    int unsigned r0;
    p0 = rd_ptr;
    m0 = m_cnt;
    dif.matmul_busy = 1'b1;
    push(M3);
    push(W5);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (dif.fifo_next_en !== 1'b0) $display("FAIL rm_next_en: got %b want 0", dif.fifo_next_en); else n_pass++;
    n_chk++; if ({dif.weight_en, dif.matmul_en, dif.activate_en} !== 3'b000) $display("FAIL rm_en: got %b want 000", {dif.weight_en, dif.matmul_en, dif.activate_en}); else n_pass++;
    n_chk++; if (dif.weight_instr !== 80'h0) $display("FAIL rm_weight_instr: got %h want 0", dif.weight_instr); else n_pass++;
    n_chk++; if (dif.matmul_instr !== 80'h0) $display("FAIL rm_matmul_instr: got %h want 0", dif.matmul_instr); else n_pass++;
    n_chk++; if (dif.activate_instr !== 80'h0) $display("FAIL rm_activate_instr: got %h want 0", dif.activate_instr); else n_pass++;
    n_chk++; if ({dif.synchronize, dif.halted, dif.illegal_op} !== 3'b000) $display("FAIL rm_flags: got %b want 000", {dif.synchronize, dif.halted, dif.illegal_op}); else n_pass++;
    dif.matmul_busy = 1'b0;
    repeat (2) @(negedge clk);
    r0 = rd_ptr;
    rst = 1'b1;
    #1;
    n_chk++; if (r0 - p0 !== 1) $display("FAIL rm_no_pop_in_reset: got %0d want 1", r0 - p0); else n_pass++;
    n_chk++; if (dif.fifo_next_en !== 1'b1) $display("FAIL rm_fresh_pop: got %b want 1", dif.fifo_next_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.matmul_en !== 1'b0) $display("FAIL rm_mm_en_t1: got %b want 0", dif.matmul_en); else n_pass++;
    @(negedge clk);
    n_chk++; if (dif.weight_en !== 1'b1) $display("FAIL rm_wt_en: got %b want 1", dif.weight_en); else n_pass++;
    n_chk++; if (dif.weight_instr !== W5) $display("FAIL rm_wt_instr: got %h want %h", dif.weight_instr, W5); else n_pass++;
    @(negedge clk);
    n_chk++; if (m_cnt - m0 !== 0) $display("FAIL rm_no_mm_en: got %0d want 0", m_cnt - m0); else n_pass++;
    $display("reset_mid: weight_instr=%h", dif.weight_instr);
  endtask

  initial begin
    dif.weight_busy   = 1'b0;
    dif.matmul_busy   = 1'b0;
    dif.activate_busy = 1'b0;
    dif.resume        = 1'b0;
    test_reset();
    test_weight();
    test_matmul_stall();
    test_act_sync();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_dispatcher.md
Name: instr_dispatcher

Overview:
- Consumer side of the instruction FIFO.
- Pops one 80-bit instr_type per dispatch and decodes its opcode.
- Issues the instruction to the weight-load, matrix-multiply or activation unit using an en/busy handshake.
- Executes SYNC, HALT and NOP locally and reports SYNC completion to the host-side control.

Parameters:
- HOLDOFF_CYCLES, 1: cycles after an issue during which the target unit is treated as busy, regardless of its busy input.
- PERF_CNT_WIDTH, 32: width of the optional performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- fifo_data  in  80  head instruction (instr_type); valid whenever fifo_empty=0
- fifo_empty  in  1  FIFO empty
- fifo_next_en  out  1  pop the FIFO head
- weight_instr / matmul_instr / activate_instr  out  80 each  instruction to the unit
- weight_en / matmul_en / activate_en  out  1 each  one-cycle issue strobe
- weight_busy / matmul_busy / activate_busy  in  1 each  unit busy
- synchronize  out  1  one-cycle pulse when SYNC completes
- halted  out  1  dispatcher stopped on HALT
- resume  in  1  leave HALTED
- illegal_op  out  1  sticky illegal-opcode flag
- perf_issued, perf_stall  out  PERF_CNT_WIDTH each  present only with the optional feature

Behaviour:
- Field layout: op_code[7:0], calc_length[39:8], acc_addr[55:40], buffer_addr[79:56].
- Opcode decode:
  - 0x00 NOP
  - 0x01 HALT
  - 0xFF SYNC
  - 0000_1xxx WEIGHT
  - 001x_xxxx MATMUL
  - 1xxx_xxxx other than 0xFF: ACTIVATE
  - anything else: ILLEGAL
- States: FETCH, ISSUE, WAIT_SYNC, HALTED. Reset state is FETCH.
- FETCH:
  - fifo_next_en = !fifo_empty, combinational, asserted only in FETCH.
  - On a pop, fifo_data is registered into the hold register and the FSM moves to ISSUE.
  - If fifo_empty=1, stay in FETCH.
- ISSUE, WEIGHT/MATMUL/ACTIVATE:
  - Target is free when busy=0 and its holdoff counter is 0.
  - If free: the registered <unit>_en is high in the next cycle for exactly one cycle, <unit>_instr is loaded from the hold register, the holdoff counter loads HOLDOFF_CYCLES, and the FSM goes to FETCH.
  - If not free: stay in ISSUE.
  - <unit>_instr holds its value until the next issue to that unit.
- ISSUE, NOP: go to FETCH.
- ISSUE, ILLEGAL: set illegal_op (sticky until reset) and treat as NOP.
- ISSUE, SYNC: go to WAIT_SYNC.
- WAIT_SYNC: when all three units are free, the registered synchronize pulses for one cycle and the FSM goes to FETCH.
- ISSUE, HALT: go to HALTED; halted=1 from the next cycle.
- HALTED:
  - resume=1 moves to FETCH; halted clears in the same edge.
  - resume is ignored in all other states.
- Latency: head valid at cycle t gives next_en at t, ISSUE at t+1, <unit>_en at t+2 if the unit is free. Throughput is one instruction per 2 cycles.
- Ordering: strictly in-order issue. No reordering around a stalled unit.
- Units must assert busy within HOLDOFF_CYCLES cycles after their en.
- Holdoff counters decrement to 0 and saturate there.
- Reset values: all en, instr, synchronize, halted, illegal_op and counters are 0; hold register is 0.
- Reset mid-operation (rst=0 at any time): the held instruction is discarded, no further pop occurs, and the state returns to FETCH.
- Busy rising in the same cycle as the free check: the unit is treated as not free.

Optional Feature:
- Macro: INSTR_DISPATCHER_PERF_EN.
- When defined:
  - perf_issued counts <unit>_en pulses.
  - perf_stall counts cycles spent in ISSUE or WAIT_SYNC without progress.
  - Both counters wrap at 2^PERF_CNT_WIDTH and reset to 0.
- When undefined: perf_issued and perf_stall ports and their logic are absent. All other behaviour is identical.

Decomposition:
- tpu_pkg gains:
  - opcode constants: OP_NOP, OP_HALT, OP_SYNC, WEIGHT/MATMUL/ACTIVATE masks
  - field offset constants
  - dispatch_state_type enum
  - unit_sel_type enum (NONE, WEIGHT, MATMUL, ACTIVATE)
- Sub-module unit_holdoff holds one per-unit holdoff counter plus the free output. Instantiate it three times.

Test Plan:
- WEIGHT 0x08 pushed, all units idle: fifo_next_en at t, weight_en at t+2 for one cycle, weight_instr equals the pushed 80-bit value.
- MATMUL 0x20 while matmul_busy=1 for 5 cycles: no matmul_en until the cycle after busy drops; no further pops meanwhile.
- ACTIVATE 0x80, then SYNC 0xFF, with activate_busy high 4 cycles: synchronize pulses once after busy falls and holdoff is 0; the next pop follows.
- HALT 0x01, then WEIGHT queued: halted=1, no pops; resume pulse: halted=0, weight_en two cycles after the pop.
- Opcode 0x40: illegal_op=1 and stays set, no en pulses, next instruction proceeds normally.
- rst low while in ISSUE with MATMUL held: all outputs 0, no matmul_en after release, next head popped fresh.
